// File: rtl/motor_act_stream.sv
// Two-stage pipelined activation stage for N_CH signed fixed-point channels per beat
// (pass / ReLU / clipped ReLU / leaky ReLU). Optional per-vector statistics under ACT_STATS_EN.
module motor_act_stream #(
  parameter int N_CH       = 9,
  parameter int W          = 32,
  parameter int I          = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [1:0]          mode,
  input  logic [W-1:0]        clip_val,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N_CH*W-1:0]   s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N_CH*W-1:0]   m_data,
  output logic                m_last,
`ifdef ACT_STATS_EN
  output logic [15:0]         zero_cnt,
  output logic [15:0]         clip_cnt,
  output logic                stats_vld,
`endif
  output logic                busy
);

  localparam logic signed [W-1:0] ZERO = '0;

  if (LEAK_SHIFT < 1 || LEAK_SHIFT > W - 1 || I < 1 || I > W) begin : g_bad_param
    $error("motor_act_stream: LEAK_SHIFT must be 1..W-1 and I must be 1..W");
  end

  // Handshake: a beat moves on a rising edge when valid && ready are both high; a source
  // holds valid and its payload until accepted. Both stages advance together on en.
  logic en;
  assign en      = !m_valid || m_ready;
  assign s_ready = en && !ap_rst;

  logic                      s1_valid;
  logic [N_CH*W-1:0]         s1_data;
  logic                      s1_last;
  logic [1:0]                s1_mode;
  logic signed [W-1:0]       s1_clip;

  assign busy = s1_valid || m_valid;

  function automatic logic [W-1:0] act_ch(input logic signed [W-1:0] x,
                                          input logic [1:0]          md,
                                          input logic signed [W-1:0] cv);
    logic signed [W-1:0] r;
    r = (x > ZERO) ? x : ZERO;
    case (md)
      2'd0:    act_ch = x;
      2'd1:    act_ch = r;
      2'd2:    act_ch = (cv <= ZERO) ? ZERO : ((r > cv) ? cv : r);
      default: act_ch = (x >= ZERO) ? x : (x >>> LEAK_SHIFT);
    endcase
  endfunction

  logic [N_CH*W-1:0] act_data;
  always_comb begin
    act_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      act_data[k*W +: W] = act_ch($signed(s1_data[k*W +: W]), s1_mode, s1_clip);
    end
  end

`ifdef ACT_STATS_EN
  localparam int CW = $clog2(N_CH + 1);
  logic [CW-1:0] s1_zn, s1_cn, m_zn, m_cn;

  // Per-beat counts ride alongside the result so they are credited when the beat leaves.
  always_comb begin
    s1_zn = '0;
    s1_cn = '0;
    for (int k = 0; k < N_CH; k++) begin
      if ((s1_mode == 2'd1 || s1_mode == 2'd2) && ($signed(s1_data[k*W +: W]) <= ZERO))
        s1_zn = s1_zn + CW'(1);
      if (s1_mode == 2'd2 && s1_clip > ZERO && ($signed(s1_data[k*W +: W]) > s1_clip))
        s1_cn = s1_cn + CW'(1);
    end
  end
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else if (en) begin
      s1_valid <= s_valid;
      if (s_valid) begin
        s1_data <= s_data;
        s1_last <= s_last;
        s1_mode <= mode;
        s1_clip <= clip_val;
      end
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_data <= act_data;
        m_last <= s1_last;
`ifdef ACT_STATS_EN
        m_zn   <= s1_zn;
        m_cn   <= s1_cn;
`endif
      end
    end
  end

`ifdef ACT_STATS_EN
  logic        out_acc;
  logic [15:0] zbase, cbase;
  logic [16:0] zsum, csum;
  assign out_acc = m_valid && m_ready;
  assign zbase   = stats_vld ? 16'd0 : zero_cnt;
  assign cbase   = stats_vld ? 16'd0 : clip_cnt;
  assign zsum    = {1'b0, zbase} + 17'(m_zn);
  assign csum    = {1'b0, cbase} + 17'(m_cn);

  // Counts stay visible during the stats_vld cycle and restart from zero right after it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      zero_cnt  <= '0;
      clip_cnt  <= '0;
      stats_vld <= 1'b0;
    end else begin
      stats_vld <= out_acc && m_last;
      if (out_acc) begin
        zero_cnt <= zsum[16] ? 16'hFFFF : zsum[15:0];
        clip_cnt <= csum[16] ? 16'hFFFF : csum[15:0];
      end else if (stats_vld) begin
        zero_cnt <= '0;
        clip_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_motor_act_stream.sv
// Directed bench for motor_act_stream: reset, each activation mode, streaming with
// random backpressure, mid-flight mode change and reset, and (with ACT_STATS_EN) statistics.
module tb_motor_act_stream;
  localparam int N_CH = 9;
  localparam int W    = 32;
  localparam int DW   = N_CH * W;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [1:0]    mode;
  logic [W-1:0]  clip_val;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          busy;
`ifdef ACT_STATS_EN
  logic [15:0]   zero_cnt, clip_cnt;
  logic          stats_vld;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  motor_act_stream #(.N_CH(N_CH), .W(W), .I(8), .LEAK_SHIFT(3)) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .mode     (mode),
    .clip_val (clip_val),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
`ifdef ACT_STATS_EN
    .zero_cnt (zero_cnt),
    .clip_cnt (clip_cnt),
    .stats_vld(stats_vld),
`endif
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input logic [W-1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  // Reference activation written from the sign bit, independent of signed compares.
  function automatic logic [W-1:0] ref_ch(input logic [W-1:0] x, input logic [1:0] md,
                                          input logic [W-1:0] cv);
    case (md)
      2'd0: return x;
      2'd1: return (x[W-1] || x == 0) ? '0 : x;
      2'd2: begin
        if (cv[W-1] || cv == 0 || x[W-1]) return '0;
        return (x > cv) ? cv : x;
      end
      default: return x[W-1] ? {3'b111, x[W-1:3]} : x;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input logic [1:0] md,
                                             input logic [W-1:0] cv);
    logic [DW-1:0] y;
    for (int k = 0; k < N_CH; k++) y[k*W +: W] = ref_ch(d[k*W +: W], md, cv);
    return y;
  endfunction

  // Drives one beat from an empty pipeline with m_ready=1; checks 2-cycle latency and result.
  task automatic run_beat(input string tag, input logic [1:0] md, input logic [W-1:0] cv,
                          input logic [DW-1:0] d, input logic lst, input logic [DW-1:0] exp_d);
    mode = md; clip_val = cv; s_data = d; s_last = lst; s_valid = 1'b1; m_ready = 1'b1;
    #1 chk({tag, "_s_ready"}, s_ready, 1'b1);
    @(negedge ap_clk);
    s_valid = 1'b0;
    chk({tag, "_not_early"}, m_valid, 1'b0);
    @(negedge ap_clk);
    chk({tag, "_m_valid"}, m_valid, 1'b1);
    chk(tag, {m_last, m_data}, {lst, exp_d});
    @(negedge ap_clk);
    chk({tag, "_drained"}, busy, 1'b0);
  endtask

  logic [DW:0]   exp_q[$];
  logic [DW:0]   e, prev_out;
  logic [DW-1:0] dv;
  logic          prev_stall, hold, found;
  int            sent, got;

  initial begin
    ap_rst = 1'b1; mode = 2'd0; clip_val = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
`ifdef ACT_STATS_EN
    chk("rst_stats", {stats_vld, zero_cnt, clip_cnt}, '0);
`endif
    ap_rst = 1'b0;
    #1 chk("post_rst_s_ready", s_ready, 1'b1);
    @(negedge ap_clk);

    // ReLU and pass with sign/limit corner values
    dv = pk(32'h01000000, 32'hFF000000, 32'h0, 32'h7FFFFFFF, 32'h80000000,
            32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'hC0000000);
    run_beat("relu", 2'd1, 32'h0, dv, 1'b1,
             pk(32'h01000000, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h0,
                32'h00000001, 32'h0, 32'h12345678, 32'h0));
    run_beat("pass", 2'd0, 32'h0, dv, 1'b0, dv);

    // Clipped ReLU: above, below, equal, one over, negatives
    dv = pk(32'h01000000, 32'h00400000, 32'hFFF00000, 32'h00800000, 32'h00800001,
            32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h00000001);
    run_beat("clip_pos", 2'd2, 32'h00800000, dv, 1'b0,
             pk(32'h00800000, 32'h00400000, 32'h0, 32'h00800000, 32'h00800000,
                32'h0, 32'h0, 32'h00800000, 32'h00000001));
    run_beat("clip_neg_ceiling", 2'd2, 32'hFF000000, dv, 1'b0, '0);
    run_beat("clip_zero_ceiling", 2'd2, 32'h0, dv, 1'b0, '0);

    // Leaky ReLU, slope 1/8, floor rounding
    dv = pk(32'hF8000000, 32'hFFFFFFFF, 32'h00000005, 32'h0, 32'h80000000,
            32'hFFFFFFF8, 32'hFFFFFFF0, 32'h7FFFFFFF, 32'hFFFFFFF7);
    run_beat("leaky", 2'd3, 32'h0, dv, 1'b1,
             pk(32'hFF000000, 32'hFFFFFFFF, 32'h00000005, 32'h0, 32'hF0000000,
                32'hFFFFFFFF, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFE));

    // Stream of 20 beats with random backpressure and random modes
    clip_val = 32'h00800000;
    sent = 0; got = 0; prev_stall = 1'b0; hold = 1'b0; s_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      if (prev_stall) chk("stream_stall_hold", {m_last, m_data}, prev_out);
      m_ready = 1'($urandom_range(0, 1));
      if (!hold) begin
        if (sent < 20 && $urandom_range(0, 3) != 0) begin
          for (int k = 0; k < N_CH; k++) s_data[k*W +: W] = $urandom;
          s_last  = (sent % 5 == 4);
          mode    = 2'($urandom_range(0, 3));
          s_valid = 1'b1;
        end else begin
          s_valid = 1'b0;
        end
      end
      #1;
      chk("stream_s_ready_rule", s_ready, !m_valid || m_ready);
      if (s_valid && s_ready) begin
        exp_q.push_back({s_last, ref_beat(s_data, mode, clip_val)});
        sent++;
      end
      hold = s_valid && !s_ready;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("stream_extra_beat", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("stream_beat", {m_last, m_data}, e);
        end
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_last, m_data};
      @(negedge ap_clk);
    end
    chk("stream_sent", sent, 20);
    chk("stream_received", got, 20);
    chk("stream_queue_empty", exp_q.size(), 0);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge ap_clk);

    // Mode switched right after beat A is accepted; beat B follows
    dv = pk(32'hF8000000, 32'hFFFFFFFF, 32'h00000005, 32'h0, 32'h80000000,
            32'hFFFFFFF8, 32'hFFFFFFF0, 32'h7FFFFFFF, 32'hFFFFFFF7);
    mode = 2'd1; s_data = dv; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    @(negedge ap_clk);
    mode = 2'd3; s_last = 1'b1;
    @(negedge ap_clk);
    s_valid = 1'b0;
    chk("modesw_a_relu", {m_last, m_data},
        {1'b0, pk(32'h0, 32'h0, 32'h00000005, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h0)});
    @(negedge ap_clk);
    chk("modesw_b_leaky", {m_last, m_data},
        {1'b1, pk(32'hFF000000, 32'hFFFFFFFF, 32'h00000005, 32'h0, 32'hF0000000,
                  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFE)});
    @(negedge ap_clk);

    // Reset with two beats in flight
    mode = 2'd0; s_data = pk(1, 2, 3, 4, 5, 6, 7, 8, 9); s_valid = 1'b1;
    @(negedge ap_clk);
    s_data = pk(9, 8, 7, 6, 5, 4, 3, 2, 1);
    @(negedge ap_clk);
    s_valid = 1'b0; m_ready = 1'b0;
    chk("inflight_busy", busy, 1'b1);
    chk("inflight_m_valid", m_valid, 1'b1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_m_data", m_data, '0);
    chk("midrst_s_ready", s_ready, 1'b0);
    ap_rst = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      chk("midrst_no_reemit", m_valid, 1'b0);
    end

`ifdef ACT_STATS_EN
    // 3-beat clipped vector: 4 channels forced to zero, 2 limited (an equal value is not)
    mode = 2'd2; clip_val = 32'h00800000; m_ready = 1'b1; s_valid = 1'b1; s_last = 1'b0;
    s_data = pk(32'hFF000000, 32'h80000000, 32'h01000000, 32'h00100000, 32'h00100000,
                32'h00100000, 32'h00100000, 32'h00100000, 32'h00100000);
    @(negedge ap_clk);
    s_data = pk(32'h0, 32'h00800001, 32'h00100000, 32'h00100000, 32'h00100000,
                32'h00100000, 32'h00100000, 32'h00100000, 32'h00100000);
    @(negedge ap_clk);
    s_data = pk(32'hFFFFFFFF, 32'h00800000, 32'h00100000, 32'h00100000, 32'h00100000,
                32'h00100000, 32'h00100000, 32'h00100000, 32'h00100000);
    s_last = 1'b1;
    @(negedge ap_clk);
    s_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge ap_clk);
      if (stats_vld) found = 1'b1;
    end
    chk("stats_pulse_seen", found, 1'b1);
    chk("stats_zero_cnt", zero_cnt, 16'd4);
    chk("stats_clip_cnt", clip_cnt, 16'd2);
    @(negedge ap_clk);
    chk("stats_pulse_width", stats_vld, 1'b0);
    chk("stats_zero_clear", zero_cnt, 16'd0);
    chk("stats_clip_clear", clip_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
